la_capture_fsm: RTL and testbench

Capture controller for the logic-analyzer core. It consumes the `trig` output of the per-probe trigger block and sequences sample-memory writes: pre-trigger fill, armed wait, post-trigger capture, done. It generates the BRAM write enable and write address, and reports state and read-start pointer to host-visible registers. Sample data is written externally, aligned to the same cycle as `trig`.

---
 rtl/la_pkg.sv | 19 +
 rtl/la_rise_detect.sv | 31 +++
 rtl/la_capture_fsm.sv | 144 ++++++++++++++
 tb/tb_la_capture_fsm.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : la_pkg
//  Description : Shared definitions for the logic-analyzer capture path:
//                capture FSM state encodings and state-field width.
//  Revision    : 1.0 - initial release
// ============================================================================
package la_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE             = 3'd0;
    localparam logic [STATE_W-1:0] ST_MOVE_TO_POSITION = 3'd1;
    localparam logic [STATE_W-1:0] ST_IN_POSITION      = 3'd2;
    localparam logic [STATE_W-1:0] ST_CAPTURING        = 3'd3;
    localparam logic [STATE_W-1:0] ST_CAPTURED         = 3'd4;

endpackage : la_pkg
`default_nettype wire

// File: rtl/la_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module      : la_rise_detect
//  Description : 1-bit rising-edge detector. The level is registered once and
//                the output pulses for the cycle in which the input is high
//                while its registered copy is still low.
//  Revision    : 1.0 - initial release
// ============================================================================
module la_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    // Delayed copy of the level; cleared by reset so a level already high at
    // reset release counts as a fresh rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule : la_rise_detect
`default_nettype wire

// File: rtl/la_capture_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : la_capture_fsm
//  Description : Logic-analyzer capture controller. Sequences sample-memory
//                writes through pre-trigger fill, armed wait, post-trigger
//                capture and done; drives BRAM write enable/address and
//                reports state and the read-start pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module la_capture_fsm
    import la_pkg::*;
#(
    parameter int SAMPLE_DEPTH = 1024,
    parameter int ADDR_WIDTH   = $clog2(SAMPLE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  request_start,
    input  logic                  request_stop,
    input  logic [ADDR_WIDTH-1:0] trigger_loc,
    input  logic                  trig,
    output logic [STATE_W-1:0]    state,
    output logic [ADDR_WIDTH-1:0] write_pointer,
    output logic [ADDR_WIDTH-1:0] read_pointer,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr
);

    localparam logic [ADDR_WIDTH-1:0] c_max_loc     = ADDR_WIDTH'(SAMPLE_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_max_loc_ext = (ADDR_WIDTH + 1)'(SAMPLE_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   c_cnt_one     = (ADDR_WIDTH + 1)'(1);

    logic [STATE_W-1:0]    r_state;
    logic [ADDR_WIDTH-1:0] r_wp;
    logic [ADDR_WIDTH-1:0] r_rp;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [ADDR_WIDTH-1:0] r_loc;

    logic                  w_start_evt;
    logic                  w_stop_evt;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_loc_clamped;
    logic [ADDR_WIDTH-1:0] w_remain;
    logic [ADDR_WIDTH:0]   w_cnt_inc;

    la_rise_detect u_start_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (request_start),
        .o_rise  (w_start_evt)
    );

    la_rise_detect u_stop_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (request_stop),
        .o_rise  (w_stop_evt)
    );

    // Write enable decoded straight from the state register: the three
    // filling states write every cycle they are resident.
    assign w_we = (r_state == ST_MOVE_TO_POSITION) ||
                  (r_state == ST_IN_POSITION)      ||
                  (r_state == ST_CAPTURING);

    // The clamp is unreachable at the current port width but guards against
    // a wider trigger_loc being connected later.
    assign w_loc_clamped = ({1'b0, trigger_loc} > c_max_loc_ext) ? c_max_loc : trigger_loc;

    // Samples still to be written after the trigger sample so that the buffer
    // ends up holding exactly SAMPLE_DEPTH samples.
    assign w_remain  = c_max_loc - r_loc;
    assign w_cnt_inc = r_cnt + c_cnt_one;

    // Capture state machine with inline pointer and sample-count bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_loc   <= '0;
        end else begin
            // Every written sample advances the write pointer, including the
            // write that coincides with a stop event.
            if (w_we) begin
                r_wp <= r_wp + c_ptr_one;
            end

            if (w_stop_evt) begin
                // Stop overrides everything; pointers are left as-is so a
                // partial capture remains readable.
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start_evt) begin
                            r_wp    <= '0;
                            r_rp    <= '0;
                            r_cnt   <= '0;
                            r_loc   <= w_loc_clamped;
                            r_state <= (w_loc_clamped != '0) ? ST_MOVE_TO_POSITION
                                                             : ST_IN_POSITION;
                        end
                    end
                    ST_MOVE_TO_POSITION: begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == {1'b0, r_loc}) begin
                            r_state <= ST_IN_POSITION;
                        end
                    end
                    ST_IN_POSITION: begin
                        if (trig) begin
                            r_rp    <= r_wp - r_loc;
                            r_cnt   <= {1'b0, w_remain};
                            r_state <= (w_remain != '0) ? ST_CAPTURING : ST_CAPTURED;
                        end
                    end
                    ST_CAPTURING: begin
                        r_cnt <= r_cnt - c_cnt_one;
                        if (r_cnt == c_cnt_one) begin
                            r_state <= ST_CAPTURED;
                        end
                    end
                    ST_CAPTURED: begin
                        r_state <= ST_CAPTURED;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign state         = r_state;
    assign write_pointer = r_wp;
    assign read_pointer  = r_rp;
    assign bram_we       = w_we;
    assign bram_addr     = r_wp;

endmodule : la_capture_fsm
`default_nettype wire

// File: tb/tb_la_capture_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_la_capture_fsm
//  Description : Self-checking bench for la_capture_fsm at SAMPLE_DEPTH=8.
//                A vector table drives complete captures; expected write
//                addresses are queued when a capture is launched and popped
//                as the DUT writes. Hand sequences cover stop, simultaneous
//                start/stop and asynchronous reset mid-capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_la_capture_fsm;
    import la_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    typedef struct {
        logic [AW-1:0]      loc;
        int                 t_from;
        int                 t_to;
        int                 k;
        logic [STATE_W-1:0] first_st;
        logic [AW-1:0]      exp_wp;
        logic [AW-1:0]      exp_rp;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               request_start = 1'b0;
    logic               request_stop = 1'b0;
    logic [AW-1:0]      trigger_loc = '0;
    logic               trig = 1'b0;
    logic [STATE_W-1:0] state;
    logic [AW-1:0]      write_pointer;
    logic [AW-1:0]      read_pointer;
    logic               bram_we;
    logic [AW-1:0]      bram_addr;

    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] exp_q[$];
    vec_t          vecs[4];

    la_capture_fsm #(
        .SAMPLE_DEPTH (DEPTH),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .request_start (request_start),
        .request_stop  (request_stop),
        .trigger_loc   (trigger_loc),
        .trig          (trig),
        .state         (state),
        .write_pointer (write_pointer),
        .read_pointer  (read_pointer),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every DUT write must match the next queued address.
    always @(negedge clk) begin
        logic [AW-1:0] e;
        if (rst_n && bram_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d expected no write", bram_addr);
            end else begin
                e = exp_q.pop_front();
                check("bram_addr", bram_addr, e);
            end
        end
    end

    task automatic push_writes(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(AW'(i % DEPTH));
    endtask

    task automatic pulse_start(input logic [AW-1:0] loc);
        trigger_loc   = loc;
        request_start = 1'b1;
        @(negedge clk);
        request_start = 1'b0;
        trigger_loc   = ~loc;   // must have been latched already
    endtask

    task automatic go_idle();
        request_stop = 1'b1;
        @(negedge clk);
        request_stop = 1'b0;
        check("idle_after_stop", state, ST_IDLE);
        @(negedge clk);
    endtask

    task automatic run_capture(input vec_t v);
        int n;
        n = DEPTH + v.k;
        push_writes(n);
        pulse_start(v.loc);
        check("first_state", state, v.first_st);
        for (int j = 0; j < n + 4 && state != ST_CAPTURED; j++) begin
            trig = (j >= v.t_from) && (j <= v.t_to);
            @(negedge clk);
        end
        trig = 1'b0;
        check("final_state", state, ST_CAPTURED);
        check("final_wp", write_pointer, v.exp_wp);
        check("final_rp", read_pointer, v.exp_rp);
        check("final_we", bram_we, 1'b0);
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        check("captured_hold_wp", write_pointer, v.exp_wp);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // loc, trig window (write index), k, first state, final wp, final rp
        vecs[0] = '{loc: 3'd3, t_from: 4, t_to: 4, k: 1, first_st: ST_MOVE_TO_POSITION, exp_wp: 3'd1, exp_rp: 3'd1};
        vecs[1] = '{loc: 3'd0, t_from: 0, t_to: 3, k: 0, first_st: ST_IN_POSITION,      exp_wp: 3'd0, exp_rp: 3'd0};
        vecs[2] = '{loc: 3'd7, t_from: 9, t_to: 9, k: 2, first_st: ST_MOVE_TO_POSITION, exp_wp: 3'd2, exp_rp: 3'd2};
        vecs[3] = '{loc: 3'd4, t_from: 0, t_to: 4, k: 0, first_st: ST_MOVE_TO_POSITION, exp_wp: 3'd0, exp_rp: 3'd0};

        #2;
        check("rst_state", state, ST_IDLE);
        check("rst_wp", write_pointer, 0);
        check("rst_rp", read_pointer, 0);
        check("rst_we", bram_we, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            go_idle();
            run_capture(vecs[i]);
        end

        // Stop during CAPTURING: L=3, trigger at write 4, stop seen after write 6.
        go_idle();
        push_writes(7);
        pulse_start(3'd3);
        for (int j = 0; j < 7; j++) begin
            trig         = (j == 4);
            request_stop = (j == 6);
            @(negedge clk);
        end
        trig         = 1'b0;
        request_stop = 1'b0;
        check("stop_state", state, ST_IDLE);
        check("stop_we", bram_we, 1'b0);
        check("stop_wp", write_pointer, 7);
        check("stop_rp", read_pointer, 1);
        check("stop_queue", exp_q.size(), 0);
        @(negedge clk);
        check("stop_hold_wp", write_pointer, 7);

        // Start and stop rising together while IDLE: stop wins.
        request_start = 1'b1;
        request_stop  = 1'b1;
        @(negedge clk);
        check("both_state", state, ST_IDLE);
        request_start = 1'b0;
        request_stop  = 1'b0;
        @(negedge clk);
        check("both_state2", state, ST_IDLE);
        check("both_we", bram_we, 1'b0);
        check("both_wp", write_pointer, 7);

        // Asynchronous reset during CAPTURING.
        exp_q.delete();
        push_writes(6);
        pulse_start(3'd3);
        for (int j = 0; j < 5; j++) begin
            trig = (j == 4);
            @(negedge clk);
        end
        trig = 1'b0;
        check("pre_rst_state", state, ST_CAPTURING);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_state", state, ST_IDLE);
        check("async_rst_wp", write_pointer, 0);
        check("async_rst_rp", read_pointer, 0);
        check("async_rst_we", bram_we, 1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_queue", exp_q.size(), 0);
        exp_q.delete();
        run_capture(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_la_capture_fsm
`default_nettype wire
